// File: rtl/disp_pkg.sv
// Shared display-path types and constants.
// Used by the pixel scheduler, static decoder and display driver.
package disp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_GAP,
        ST_PIXEL,
        ST_DONE
    } disp_state_t;

    localparam logic [1:0] MODE_STAT = 2'd0;
    localparam logic [1:0] MODE_OR   = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_DYN  = 2'd3;

    localparam int DISP_H_RES     = 240;
    localparam int DISP_V_RES     = 160;
    localparam int DISP_WIN_X0    = 16;
    localparam int DISP_WIN_Y0    = 16;
    localparam int DISP_WIN_W     = 208;
    localparam int DISP_WIN_H     = 128;
    localparam int DISP_FLUSH_CYC = 2;

    // Outside the window the static pixel always wins.
    function automatic logic px_merge(
        input logic [1:0] mode,
        input logic       in_win,
        input logic       s,
        input logic       d
    );
        logic r;
        r = s;
        if (in_win) begin
            unique case (mode)
                MODE_OR:  r = s | d;
                MODE_XOR: r = s ^ d;
                MODE_DYN: r = d;
                default:  r = s;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/px_raster_cnt.sv
// Raster position counter for the pixel scheduler.
// Tracks x/y and flags window membership and frame corners.
module px_raster_cnt
    import disp_pkg::*;
#(
    parameter int H_RES  = DISP_H_RES,
    parameter int V_RES  = DISP_V_RES,
    parameter int WIN_X0 = DISP_WIN_X0,
    parameter int WIN_Y0 = DISP_WIN_Y0,
    parameter int WIN_W  = DISP_WIN_W,
    parameter int WIN_H  = DISP_WIN_H
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic adv,
    output logic in_win,
    output logic at_first,
    output logic at_last
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_win;
    logic          y_win;

    // Step one raster position per accepted pixel, wrapping at frame end.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign x_win = (int'(x) >= WIN_X0) &&
                   (int'(x) <  WIN_X0 + WIN_W);
    assign y_win = (int'(y) >= WIN_Y0) &&
                   (int'(y) <  WIN_Y0 + WIN_H);

    assign in_win   = x_win && y_win;
    assign at_first = (x == '0) && (y == '0);
    assign at_last  = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/disp_px_sched.sv
// Frame scheduler and compositor for the display pixel path.
// Flushes the static decoder, then merges static and dynamic pixels.
module disp_px_sched
    import disp_pkg::*;
#(
    parameter int H_RES     = DISP_H_RES,
    parameter int V_RES     = DISP_V_RES,
    parameter int WIN_X0    = DISP_WIN_X0,
    parameter int WIN_Y0    = DISP_WIN_Y0,
    parameter int WIN_W     = DISP_WIN_W,
    parameter int WIN_H     = DISP_WIN_H,
    parameter int FLUSH_CYC = DISP_FLUSH_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic [1:0] mode,
    output logic       busy,
    output logic       frame_done,
    output logic       stat_flush,
    input  logic       stat_valid,
    input  logic       stat_px,
    output logic       stat_ready,
    input  logic       dyn_valid,
    input  logic       dyn_px,
    output logic       dyn_ready,
    output logic       px_valid,
    output logic       px_out,
    output logic       px_first,
    output logic       px_last,
    input  logic       px_ready
);

    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    disp_state_t   state;
    disp_state_t   state_nx;
    logic [1:0]    mode_q;
    logic [FW-1:0] flush_cnt;
    logic          last_taken;

    logic in_win;
    logic at_first;
    logic at_last;
    logic need_dyn;
    logic slot_free;
    logic take;
    logic flush_end;
    logic out_last_hs;
    logic raster_clr;

    assign raster_clr = (state == ST_IDLE);

    px_raster_cnt #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .WIN_X0 (WIN_X0),
        .WIN_Y0 (WIN_Y0),
        .WIN_W  (WIN_W),
        .WIN_H  (WIN_H)
    ) u_raster (
        .clk      (clk),
        .rst      (rst),
        .clr      (raster_clr),
        .adv      (take),
        .in_win   (in_win),
        .at_first (at_first),
        .at_last  (at_last)
    );

    // Static is pulled at every position so it stays raster-aligned;
    // dynamic only where it actually contributes.
    assign need_dyn  = in_win && (mode_q != MODE_STAT);
    assign slot_free = !px_valid || px_ready;
    assign take      = (state == ST_PIXEL) && !last_taken &&
                       stat_valid && (!need_dyn || dyn_valid) &&
                       slot_free;

    assign stat_ready = take;
    assign dyn_ready  = take && need_dyn;

    assign flush_end   = (flush_cnt == FW'(FLUSH_CYC - 1));
    assign out_last_hs = px_valid && px_ready && px_last;

    assign busy       = (state == ST_FLUSH) ||
                        (state == ST_GAP)   ||
                        (state == ST_PIXEL);
    assign frame_done = (state == ST_DONE);
    assign stat_flush = (state == ST_FLUSH);

    // Frame sequencing: flush, one idle gap, raster, done pulse.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (frame_start) state_nx = ST_FLUSH;
            ST_FLUSH: if (flush_end)   state_nx = ST_GAP;
            ST_GAP:   state_nx = ST_PIXEL;
            ST_PIXEL: if (out_last_hs) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // State register, frame mode latch, flush timer, last-take guard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_STAT;
            flush_cnt  <= '0;
            last_taken <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && frame_start)
                mode_q <= mode;
            if (state == ST_FLUSH)
                flush_cnt <= flush_cnt + 1'b1;
            else
                flush_cnt <= '0;
            if (state != ST_PIXEL)
                last_taken <= 1'b0;
            else if (take && at_last)
                last_taken <= 1'b1;
        end
    end

    // Single-entry output register; holds steady under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            px_valid <= 1'b0;
            px_out   <= 1'b0;
            px_first <= 1'b0;
            px_last  <= 1'b0;
        end else if (take) begin
            px_valid <= 1'b1;
            px_out   <= px_merge(mode_q, in_win, stat_px, dyn_px);
            px_first <= at_first;
            px_last  <= at_last;
        end else if (px_ready) begin
            px_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_disp_px_sched.sv
// Randomized bench for disp_px_sched on a small 8x4 raster.
// Expected pixels come from a per-position array model.
module tb_disp_px_sched;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int WX = 2;
    localparam int WY = 1;
    localparam int WW = 4;
    localparam int WH = 2;
    localparam int N  = H * V;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic [1:0] mode;
    logic       busy;
    logic       frame_done;
    logic       stat_flush;
    logic       stat_valid;
    logic       stat_px;
    logic       stat_ready;
    logic       dyn_valid;
    logic       dyn_px;
    logic       dyn_ready;
    logic       px_valid;
    logic       px_out;
    logic       px_first;
    logic       px_last;
    logic       px_ready;

    always #5 clk = ~clk;

    disp_px_sched #(
        .H_RES     (H),
        .V_RES     (V),
        .WIN_X0    (WX),
        .WIN_Y0    (WY),
        .WIN_W     (WW),
        .WIN_H     (WH),
        .FLUSH_CYC (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .mode        (mode),
        .busy        (busy),
        .frame_done  (frame_done),
        .stat_flush  (stat_flush),
        .stat_valid  (stat_valid),
        .stat_px     (stat_px),
        .stat_ready  (stat_ready),
        .dyn_valid   (dyn_valid),
        .dyn_px      (dyn_px),
        .dyn_ready   (dyn_ready),
        .px_valid    (px_valid),
        .px_out      (px_out),
        .px_first    (px_first),
        .px_last     (px_last),
        .px_ready    (px_ready)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    logic stat_seq [N];
    logic dyn_seq  [N];
    logic exp_px   [N];
    int   exp_dyn;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Source patterns: 0 all zero, 1 all one, 2 random.
    task automatic build(input logic [1:0] m, input int sp, input int dp);
        int  k;
        int  x;
        int  y;
        bit  w;
        k = 0;
        for (int i = 0; i < N; i++) begin
            stat_seq[i] = (sp == 2) ? 1'($urandom_range(0, 1)) : 1'(sp);
            dyn_seq[i]  = (dp == 2) ? 1'($urandom_range(0, 1)) : 1'(dp);
        end
        for (int i = 0; i < N; i++) begin
            x = i % H;
            y = i / H;
            w = (x >= WX) && (x < WX + WW) && (y >= WY) && (y < WY + WH);
            if (!w || m == 2'd0) begin
                exp_px[i] = stat_seq[i];
            end else begin
                case (m)
                    2'd1:    exp_px[i] = stat_seq[i] | dyn_seq[k];
                    2'd2:    exp_px[i] = stat_seq[i] ^ dyn_seq[k];
                    default: exp_px[i] = dyn_seq[k];
                endcase
                k++;
            end
        end
        exp_dyn = k;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        frame_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ctl", {busy, frame_done, stat_flush}, 0);
        chk("rst_rdy", {stat_ready, dyn_ready}, 0);
        chk("rst_px", {px_valid, px_out, px_first, px_last}, 0);
    endtask

    task automatic start_frame(input logic [1:0] m);
        @(negedge clk);
        frame_start = 1'b1;
        mode        = m;
        stat_valid  = 1'b1;
        dyn_valid   = 1'b1;
        px_ready    = 1'b1;
        #1;
        chk("idle_busy", busy, 0);
        @(negedge clk);
        frame_start = 1'b0;
        #1;
        chk("flush1", {busy, stat_flush, stat_ready}, 3'b110);
        @(negedge clk);
        #1;
        chk("flush2", {busy, stat_flush, stat_ready}, 3'b110);
        @(negedge clk);
        #1;
        chk("gap", {busy, stat_flush, stat_ready}, 3'b100);
    endtask

    // rdy_pat: 0 held high, 1 toggling, 2 random.
    task automatic run_frame(
        input logic [1:0] m,
        input int         rdy_pat,
        input bit         rnd,
        input int         hold_at,
        input int         abort_at
    );
        int   s_idx;
        int   d_idx;
        int   o_idx;
        int   hold_cnt;
        bit   holding;
        bit   done;
        bit   stall;
        bit   tog;
        logic h_px;
        logic h_f;
        logic h_l;
        s_idx    = 0;
        d_idx    = 0;
        o_idx    = 0;
        hold_cnt = 0;
        done     = 0;
        stall    = 0;
        tog      = 1;
        h_px     = 0;
        h_f      = 0;
        h_l      = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (abort_at >= 0 && o_idx == abort_at)
                return;
            frame_start = (c == 7);
            mode        = ~m;
            stat_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            stat_px     = (s_idx < N) ? stat_seq[s_idx] : 1'b0;
            holding     = (s_idx == hold_at) && (hold_cnt < 5);
            if (holding)
                dyn_valid = 1'b0;
            else
                dyn_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            dyn_px = (d_idx < N) ? dyn_seq[d_idx] : 1'b0;
            case (rdy_pat)
                0: px_ready = 1'b1;
                1: begin
                    px_ready = tog;
                    tog      = ~tog;
                end
                default: px_ready = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            if (holding) begin
                hold_cnt++;
                chk("hold_sready", stat_ready, 0);
            end
            if (stall) begin
                chk("stall_valid", px_valid, 1);
                chk("stall_px", px_out, h_px);
                chk("stall_fl", {px_first, px_last}, {h_f, h_l});
            end
            if (frame_done) begin
                done = 1;
            end else begin
                chk("busy_flush", {busy, stat_flush}, 2'b10);
                if (dyn_ready)
                    chk("dyn_no_stat", stat_ready, 1);
                if (px_valid && !px_ready)
                    chk("bp_ready", {stat_ready, dyn_ready}, 0);
                if (px_valid && px_ready) begin
                    if (o_idx < N) begin
                        chk("px_out", px_out, exp_px[o_idx]);
                        chk("px_first", px_first, o_idx == 0);
                        chk("px_last", px_last, o_idx == N - 1);
                    end else begin
                        chk("extra_px", o_idx, N - 1);
                    end
                end
                stall = px_valid && !px_ready;
                h_px  = px_out;
                h_f   = px_first;
                h_l   = px_last;
                s_idx += int'(stat_ready);
                d_idx += int'(dyn_ready);
                o_idx += int'(px_valid && px_ready);
            end
        end
        chk("timeout", done, 1);
        chk("out_cnt", o_idx, N);
        chk("stat_cnt", s_idx, N);
        chk("dyn_cnt", d_idx, exp_dyn);
        if (hold_at >= 0)
            chk("hold_cnt", hold_cnt, 5);
        // frame_start during the done cycle must be dropped
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        #1;
        chk("done_pulse", frame_done, 0);
        chk("done_ign1", {busy, stat_flush}, 0);
        @(negedge clk);
        #1;
        chk("done_ign2", {busy, stat_flush}, 0);
    endtask

    initial begin
        logic [1:0] m;
        rst         = 1'b1;
        frame_start = 1'b0;
        mode        = 2'd0;
        stat_valid  = 1'b0;
        stat_px     = 1'b0;
        dyn_valid   = 1'b0;
        dyn_px      = 1'b0;
        px_ready    = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        build(2'd0, 1, 2);
        start_frame(2'd0);
        run_frame(2'd0, 0, 0, -1, -1);

        build(2'd3, 0, 1);
        start_frame(2'd3);
        run_frame(2'd3, 0, 0, -1, -1);

        build(2'd2, 1, 1);
        start_frame(2'd2);
        run_frame(2'd2, 0, 0, 10, -1);

        build(2'd1, 2, 2);
        start_frame(2'd1);
        run_frame(2'd1, 1, 0, -1, -1);

        build(2'd2, 2, 2);
        start_frame(2'd2);
        run_frame(2'd2, 2, 1, -1, -1);

        build(2'd3, 2, 2);
        start_frame(2'd3);
        run_frame(2'd3, 0, 0, -1, 13);
        do_reset();
        start_frame(2'd3);
        run_frame(2'd3, 0, 0, -1, -1);

        for (int r = 0; r < 4; r++) begin
            m = 2'($urandom_range(0, 3));
            build(m, 2, 2);
            start_frame(m);
            run_frame(m, 2, 1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_px_sched.md
Name: disp_px_sched

Overview:
- Frame-level scheduler and compositor for the display pixel path.
- Sequences the static-pixel RLE decoder: it flushes the decoder at frame start, then pulls one static pixel per raster position.
- Inside a configurable window it merges a dynamic pixel stream (e.g. scan trace) according to a mode.
- It emits one valid/ready pixel stream, with frame markers, to the display driver.

Parameters:
- H_RES, 240, pixels per line
- V_RES, 160, lines per frame
- WIN_X0, 16, dynamic window first column
- WIN_Y0, 16, dynamic window first line
- WIN_W, 208, dynamic window width in pixels (WIN_X0+WIN_W <= H_RES)
- WIN_H, 128, dynamic window height in lines (WIN_Y0+WIN_H <= V_RES)
- FLUSH_CYC, 2, cycles stat_flush is held high (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  request a new frame; sampled in IDLE only
- mode  in  2  0 static only, 1 OR, 2 XOR, 3 dynamic replaces static; latched at frame start
- busy  out  1  high from frame acceptance until the last pixel handshake
- frame_done  out  1  one-cycle pulse after the last pixel handshake
- stat_flush  out  1  flush to the static decoder
- stat_valid  in  1  static pixel valid
- stat_px  in  1  static pixel value
- stat_ready  out  1  static pixel consumed this cycle
- dyn_valid  in  1  dynamic pixel valid
- dyn_px  in  1  dynamic pixel value
- dyn_ready  out  1  dynamic pixel consumed this cycle
- px_valid  out  1  output pixel valid (registered)
- px_out  out  1  output pixel value (registered)
- px_first  out  1  qualifies px_valid: pixel (0,0)
- px_last  out  1  qualifies px_valid: pixel (H_RES-1,V_RES-1)
- px_ready  in  1  display accepts pixel

Behaviour:
- Reset, synchronous: all outputs 0, x=y=0, state IDLE, latched mode 0.
- States:
  - IDLE: on frame_start, latch mode, set busy, go to FLUSH.
  - FLUSH: stat_flush=1 for FLUSH_CYC cycles, then go to GAP.
  - GAP: stat_flush=0 for 1 cycle, so the decoder leaves flush and refetches word 0; then go to PIXEL.
  - PIXEL: raster transfer.
  - DONE: frame_done=1 and busy=0 for 1 cycle; then go to IDLE.
- Raster counters:
  - x in [0,H_RES-1], y in [0,V_RES-1], widths $clog2 of each.
  - x increments per accepted pixel and wraps to 0 at H_RES-1, with y incrementing.
- in_win = (x>=WIN_X0)&&(x<WIN_X0+WIN_W)&&(y>=WIN_Y0)&&(y<WIN_Y0+WIN_H).
- need_dyn = in_win && mode!=0.
- slot_free = !px_valid || px_ready.
- take = state==PIXEL && stat_valid && (!need_dyn || dyn_valid) && slot_free.
- stat_ready = take. dyn_ready = take && need_dyn.
  - The static stream is consumed at every position, including mode 3 and outside the window, so it stays raster-aligned.
  - The dynamic stream is consumed only at in-window positions when mode!=0.
- On take:
  - px_valid<=1 and px_out<=merge(stat_px,dyn_px).
  - merge: in_win&&mode==1 gives OR; in_win&&mode==2 gives XOR; in_win&&mode==3 gives dyn_px; otherwise stat_px.
  - px_first<=(x==0&&y==0) and px_last<=(x==H_RES-1&&y==V_RES-1).
- Otherwise, if px_ready, then px_valid<=0.
- Latency:
  - One cycle from take to px_valid.
  - Full throughput: one pixel per cycle while sources are valid and px_ready is held.
- On take of the last pixel, stop taking; go to DONE when that pixel's output handshake completes (px_valid&&px_ready&&px_last).
- Backpressure: px_ready low holds px_out, px_first, px_last and px_valid stable, and holds stat_ready/dyn_ready at 0.
- Simultaneous events:
  - frame_start outside IDLE is ignored.
  - frame_start in the DONE cycle is ignored; it must be reissued in IDLE.
  - A mode change mid-frame has no effect.
- Reset mid-frame: everything returns to IDLE immediately. The next frame re-flushes the decoder, so the frame restarts from ROM address 0.
- Pixel count per frame is exactly H_RES*V_RES.

Decomposition:
- Package disp_pkg holds:
  - the FSM state localparams (IDLE, FLUSH, GAP, PIXEL, DONE);
  - the mode encodings (MODE_STAT, MODE_OR, MODE_XOR, MODE_DYN);
  - the default resolution and window constants shared with stat_px and the display driver.
- One sub-module, px_raster_cnt:
  - x/y counters with an advance input;
  - outputs in_win, at_first and at_last.

Test Plan (bench params H_RES=8, V_RES=4, WIN_X0=2, WIN_Y0=1, WIN_W=4, WIN_H=2):
- Flush sequencing: frame_start pulse in IDLE -> stat_flush high exactly 2 cycles, low 1 cycle, then stat_ready may assert; busy high from the cycle after frame_start.
- Mode 0, static all-1, px_ready=1 -> 32 output pixels all 1; px_first on pixel 0, px_last on pixel 31; dyn_ready never asserts; frame_done pulses once.
- Mode 3, static all-0, dynamic all-1 -> ones exactly at x=2..5 of lines y=1..2; dyn_ready count = 8; stat_ready count = 32.
- Mode 2 with stat=1, dyn=1 -> window pixels 0, outside pixels 1; dyn_valid low for 5 cycles at (2,1) -> output stalls with no static pixel consumed.
- px_ready toggled 1/0 every cycle -> px_out stable while stalled; 32 pixels total; no duplicates or drops against the reference model.
- rst asserted at pixel 13, then frame_start -> new flush pulse; output restarts at (0,0) with px_first; frame_start during busy is ignored.
